// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD figure request path: FSM states, face/stat codes
// and the neutral/neutral selection used after reset.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETTLE    = 3'd1,
      REQUEST   = 3'd2,
      WAIT_BUSY = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   localparam logic [1:0] FACE_HAPPY   = 2'b00;
   localparam logic [1:0] FACE_SAD     = 2'b01;
   localparam logic [1:0] FACE_ILLEGAL = 2'b10;
   localparam logic [1:0] FACE_NEUTRAL = 2'b11;

   localparam logic [2:0] STAT_ENERGY  = 3'b000;
   localparam logic [2:0] STAT_FUN     = 3'b001;
   localparam logic [2:0] STAT_FOOD    = 3'b010;
   localparam logic [2:0] STAT_HEALTH  = 3'b011;
   localparam logic [2:0] STAT_NEUTRAL = 3'b100;

   localparam logic [4:0] SEL_RESET = {FACE_NEUTRAL, STAT_NEUTRAL};

   // Bits needed to count up to limit; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/lcd_code_sanitize.sv
// Combinational legalisation of face/stat codes: illegal face maps to neutral,
// out-of-range stat maps to neutral.
module lcd_code_sanitize
   import lcd_pkg::*;
(
   input  logic [1:0] face,
   input  logic [2:0] stat,
   output logic [1:0] face_ok,
   output logic [2:0] stat_ok
);

   always_comb begin
      face_ok = face;
      stat_ok = stat;
      if (face == FACE_ILLEGAL) begin
         face_ok = FACE_NEUTRAL;
      end else begin
         face_ok = face;
      end
      if (stat > STAT_NEUTRAL) begin
         stat_ok = STAT_NEUTRAL;
      end else begin
         stat_ok = stat;
      end
   end

endmodule

// File: rtl/lcd_figure_request.sv
// Debounces pet face/stat codes into a stable figure selection and handshakes it
// to the LCD writer, with ack-timeout retries, a post-draw gap and periodic refresh.
module lcd_figure_request
   import lcd_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 1_000_000,
   parameter int ACK_TIMEOUT    = 65_536,
   parameter int MIN_GAP        = 50_000,
   parameter int REFRESH_CYCLES = 50_000_000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] face_i,
   input  logic [2:0] stat_i,
   input  logic       lcd_busy_i,
   output logic       ready_o,
   output logic [4:0] select_figures_o,
   output logic       pending_o
);

   localparam int WAIT_MAX = (ACK_TIMEOUT > MIN_GAP) ? ACK_TIMEOUT : MIN_GAP;
   localparam int SW = cnt_width(SETTLE_CYCLES);
   localparam int WW = cnt_width(WAIT_MAX);
   localparam int RW = cnt_width(REFRESH_CYCLES);

   localparam int SETTLE_LAST_I = (SETTLE_CYCLES > 1)  ? SETTLE_CYCLES - 1  : 0;
   localparam int ACK_LAST_I    = (ACK_TIMEOUT > 1)    ? ACK_TIMEOUT - 1    : 0;
   localparam int GAP_LAST_I    = (MIN_GAP > 1)        ? MIN_GAP - 1        : 0;
   localparam int REF_LAST_I    = (REFRESH_CYCLES > 1) ? REFRESH_CYCLES - 1 : 0;

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LAST_I);
   localparam logic [WW-1:0] ACK_LAST    = WW'(ACK_LAST_I);
   localparam logic [WW-1:0] GAP_LAST    = WW'(GAP_LAST_I);
   localparam logic [RW-1:0] REF_LAST    = RW'(REF_LAST_I);

   state_t          state, state_nx;
   logic [1:0]      face_ok;
   logic [2:0]      stat_ok;
   logic [4:0]      cand, cand_prev;
   logic [4:0]      committed_nx;
   logic            ready_nx, pending_nx;
   logic [SW-1:0]   settle_cnt, settle_nx;
   logic [WW-1:0]   wait_cnt, wait_nx;
   logic [RW-1:0]   refresh_cnt, refresh_nx;

   lcd_code_sanitize u_sanitize (
      .face    (face_i),
      .stat    (stat_i),
      .face_ok (face_ok),
      .stat_ok (stat_ok)
   );

   // State, counters, candidate pipeline and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         cand             <= SEL_RESET;
         cand_prev        <= SEL_RESET;
         select_figures_o <= SEL_RESET;
         ready_o          <= 1'b0;
         pending_o        <= 1'b0;
         settle_cnt       <= '0;
         wait_cnt         <= '0;
         refresh_cnt      <= '0;
      end else begin
         state            <= state_nx;
         cand             <= {face_ok, stat_ok};
         cand_prev        <= cand;
         select_figures_o <= committed_nx;
         ready_o          <= ready_nx;
         pending_o        <= pending_nx;
         settle_cnt       <= settle_nx;
         wait_cnt         <= wait_nx;
         refresh_cnt      <= refresh_nx;
      end
   end

   // Next-state logic; select_figures_o doubles as the committed value.
   always_comb begin
      state_nx     = state;
      committed_nx = select_figures_o;
      ready_nx     = ready_o;
      pending_nx   = pending_o;
      settle_nx    = settle_cnt;
      wait_nx      = wait_cnt;
      refresh_nx   = refresh_cnt;
      case (state)
         IDLE: begin
            if (cand != select_figures_o) begin
               state_nx   = SETTLE;
               settle_nx  = '0;
               pending_nx = 1'b1;
            end else if ((REFRESH_CYCLES != 0) && (refresh_cnt == REF_LAST)) begin
               state_nx   = REQUEST;
               refresh_nx = '0;
               ready_nx   = 1'b1;
               wait_nx    = '0;
            end else if (refresh_cnt != REF_LAST) begin
               refresh_nx = refresh_cnt + 1'b1;
            end else begin
               refresh_nx = refresh_cnt;
            end
         end
         SETTLE: begin
            if (cand == select_figures_o) begin
               state_nx   = IDLE;
               pending_nx = 1'b0;
               refresh_nx = '0;
            end else if (cand != cand_prev) begin
               settle_nx = '0;
            end else if (settle_cnt == SETTLE_LAST) begin
               committed_nx = cand;
               state_nx     = REQUEST;
               ready_nx     = 1'b1;
               wait_nx      = '0;
            end else begin
               settle_nx = settle_cnt + 1'b1;
            end
         end
         REQUEST: begin
            // A low ready_o here is the one-cycle retry gap after an ack timeout.
            if (lcd_busy_i) begin
               state_nx = WAIT_BUSY;
               ready_nx = 1'b0;
            end else if (!ready_o) begin
               ready_nx = 1'b1;
               wait_nx  = '0;
            end else if (wait_cnt == ACK_LAST) begin
               ready_nx = 1'b0;
            end else begin
               wait_nx = wait_cnt + 1'b1;
            end
         end
         WAIT_BUSY: begin
            ready_nx = 1'b0;
            if (!lcd_busy_i) begin
               state_nx   = HOLDOFF;
               pending_nx = 1'b0;
               wait_nx    = '0;
            end else begin
               state_nx = WAIT_BUSY;
            end
         end
         HOLDOFF: begin
            if (wait_cnt == GAP_LAST) begin
               state_nx   = IDLE;
               refresh_nx = '0;
            end else begin
               wait_nx = wait_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            ready_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_figure_request.sv
// Self-checking bench for lcd_figure_request: directed sequences, a sanitise table and
// randomized traffic compared against a timestamp-based reference model.
module tb_lcd_figure_request;
   import lcd_pkg::*;

   localparam int P_SETTLE = 8;
   localparam int P_ACK    = 16;
   localparam int P_GAP    = 4;
   localparam int P_REF    = 64;

   localparam int M_IDLE = 0, M_SETTLE = 1, M_REQ = 2, M_WAIT = 3, M_HOLD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] face_i = 2'b11;
   logic [2:0] stat_i = 3'b100;
   logic       lcd_busy_i = 1'b0;
   logic       ready_o, pending_o;
   logic [4:0] select_figures_o;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] face;
      logic [2:0] stat;
      logic [4:0] sel;
   } vec_t;
   vec_t tbl [5];

   lcd_figure_request #(
      .SETTLE_CYCLES  (P_SETTLE),
      .ACK_TIMEOUT    (P_ACK),
      .MIN_GAP        (P_GAP),
      .REFRESH_CYCLES (P_REF)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .face_i           (face_i),
      .stat_i           (stat_i),
      .lcd_busy_i       (lcd_busy_i),
      .ready_o          (ready_o),
      .select_figures_o (select_figures_o),
      .pending_o        (pending_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (timestamps of phase entry) ----------------
   int         cyc = 0, m_phase = M_IDLE;
   int         t_idle = 0, t_base = 0, t_req = 0, t_hold = 0;
   logic [4:0] m_cand = 5'b11100, m_prev = 5'b11100, m_comm = 5'b11100;
   bit         m_ready = 1'b0, m_pend = 1'b0, m_valid = 1'b0;

   function automatic logic [4:0] legal(input logic [1:0] f, input logic [2:0] s);
      logic [1:0] lf;
      logic [2:0] ls;
      lf = (f == 2'd2) ? 2'd3 : f;
      ls = (s > 3'd4) ? 3'd4 : s;
      return {lf, ls};
   endfunction

   task automatic model_step(input logic rst, input logic [4:0] s, input logic busy);
      logic [4:0] c, p;
      cyc++;
      if (rst) begin
         m_valid = 1'b1; m_phase = M_IDLE; t_idle = cyc;
         m_cand = 5'b11100; m_prev = 5'b11100; m_comm = 5'b11100;
         m_ready = 1'b0; m_pend = 1'b0;
      end else begin
         c = m_cand; p = m_prev;
         m_prev = m_cand; m_cand = s;
         case (m_phase)
            M_IDLE:
               if (c != m_comm) begin
                  m_phase = M_SETTLE; t_base = cyc; m_pend = 1'b1;
               end else if (cyc - t_idle >= P_REF) begin
                  m_phase = M_REQ; t_req = cyc; m_ready = 1'b1;
               end
            M_SETTLE:
               if (c == m_comm) begin
                  m_phase = M_IDLE; m_pend = 1'b0; t_idle = cyc;
               end else if (c != p) begin
                  t_base = cyc;
               end else if (cyc - t_base >= P_SETTLE) begin
                  m_comm = c; m_phase = M_REQ; t_req = cyc; m_ready = 1'b1;
               end
            M_REQ:
               if (busy) begin
                  m_phase = M_WAIT; m_ready = 1'b0;
               end else if (!m_ready) begin
                  m_ready = 1'b1; t_req = cyc;
               end else if (cyc - t_req >= P_ACK) begin
                  m_ready = 1'b0;
               end
            M_WAIT:
               if (!busy) begin
                  m_phase = M_HOLD; m_pend = 1'b0; t_hold = cyc;
               end
            M_HOLD:
               if (cyc - t_hold >= P_GAP) begin
                  m_phase = M_IDLE; t_idle = cyc;
               end
            default: m_phase = M_IDLE;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step(reset, legal(face_i, stat_i), lcd_busy_i);
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("model_ready", int'(ready_o), int'(m_ready));
         chk("model_pending", int'(pending_o), int'(m_pend));
         chk("model_select", int'(select_figures_o), int'(m_comm));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_in(input logic [1:0] f, input logic [2:0] s);
      face_i = f;
      stat_i = s;
   endtask

   task automatic wait_ready(input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_o && n < bound);
      chk("ready_seen", int'(ready_o), 1);
   endtask

   task automatic handshake(input int busy_len);
      lcd_busy_i = 1'b1;
      @(negedge clk);
      chk("ready_drop_after_busy", int'(ready_o), 0);
      cycles(busy_len - 1);
      lcd_busy_i = 1'b0;
      cycles(P_GAP + 2);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, hi, seen;
      tbl[0] = '{FACE_ILLEGAL, STAT_ENERGY, 5'b11000};
      tbl[1] = '{FACE_SAD,     3'b111,      5'b01100};
      tbl[2] = '{FACE_HAPPY,   3'b101,      5'b00100};
      tbl[3] = '{FACE_NEUTRAL, STAT_FOOD,   5'b11010};
      tbl[4] = '{FACE_ILLEGAL, 3'b110,      5'b11100};

      // Reset state, then refresh-driven request with unchanged inputs.
      cycles(3);
      chk("reset_ready", int'(ready_o), 0);
      chk("reset_pending", int'(pending_o), 0);
      chk("reset_select", int'(select_figures_o), 28);
      reset = 1'b0;
      wait_ready(100, n);
      chk("refresh_latency", n, 64);
      chk("refresh_select", int'(select_figures_o), 28);
      chk("refresh_pending", int'(pending_o), 0);
      handshake(3);

      // Happy/health: pending after two samples, request 10 cycles after change.
      set_in(FACE_HAPPY, STAT_HEALTH);
      cycles(2);
      chk("pending_rise", int'(pending_o), 1);
      wait_ready(40, n);
      chk("change_latency", n + 2, 10);
      chk("change_select", int'(select_figures_o), 5'b00011);
      handshake(20);
      chk("select_after_draw", int'(select_figures_o), 5'b00011);

      // Glitching stat produces no request until it settles on fun.
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         set_in(FACE_HAPPY, (i % 2 == 0) ? STAT_FUN : STAT_HEALTH);
         for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (ready_o) seen++;
         end
      end
      chk("glitch_no_request", seen, 0);
      set_in(FACE_HAPPY, STAT_FUN);
      wait_ready(40, n);
      chk("glitch_latency", n, 10);
      chk("glitch_select", int'(select_figures_o), 5'b00001);
      handshake(3);

      // Sanitise table.
      for (int i = 0; i < 5; i++) begin
         set_in(tbl[i].face, tbl[i].stat);
         wait_ready(40, n);
         chk("table_latency", n, 10);
         chk("table_select", int'(select_figures_o), int'(tbl[i].sel));
         handshake(3);
      end

      // Illegal codes equal to reset value: nothing happens.
      set_in(FACE_ILLEGAL, 3'b111);
      reset = 1'b1;
      cycles(3);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready_o || pending_o) seen++;
      end
      chk("illegal_idle", seen, 0);
      chk("illegal_select", int'(select_figures_o), 28);

      // No busy response: 16 high, 1 low, high again.
      set_in(FACE_HAPPY, STAT_NEUTRAL);
      wait_ready(40, n);
      chk("retry_first_latency", n, 10);
      hi = 0;
      while (ready_o && hi < 100) begin
         hi++;
         @(negedge clk);
      end
      chk("ready_high_len", hi, 16);
      chk("retry_gap_select", int'(select_figures_o), 5'b00100);
      @(negedge clk);
      chk("retry_high_again", int'(ready_o), 1);

      // Input change while writer busy is deferred until after the gap.
      lcd_busy_i = 1'b1;
      set_in(FACE_SAD, STAT_FOOD);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (select_figures_o != 5'b00100) seen++;
      end
      chk("frozen_select", seen, 0);
      lcd_busy_i = 1'b0;
      wait_ready(60, n);
      chk("deferred_latency", n, 14);
      chk("deferred_select", int'(select_figures_o), 5'b01010);
      chk("pending_in_request", int'(pending_o), 1);

      // Reset in the middle of a request.
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_ready", int'(ready_o), 0);
      chk("midreset_pending", int'(pending_o), 0);
      chk("midreset_select", int'(select_figures_o), 28);
      cycles(2);
      reset = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) begin
            face_i = 2'($urandom_range(0, 3));
            stat_i = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, (i < 1500) ? 5 : 24) == 0) lcd_busy_i = ~lcd_busy_i;
         reset = ($urandom_range(0, 599) == 0);
      end
      reset = 1'b0;
      lcd_busy_i = 1'b0;
      cycles(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
